// File: rtl/nexi_uart_pkg.sv
// Shared definitions for the minimal UART receive path: FSM encodings,
// guard length and overrun counter sizing.
package nexi_uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK   = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  // Idle cycles after ack release so the receiver's 2-flop ack synchronizer
  // sees the low level before the next capture.
  localparam logic [1:0] GUARD_CYCLES = 2'd2;

  localparam int OVR_CNT_W = 8;

  typedef struct packed {
    logic                 flag;
    logic [OVR_CNT_W-1:0] cnt;
  } overrun_t;

  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nexi_uart_sync_fifo.sv
// Small register-based synchronous FIFO; head is read combinationally so the
// consumer sees the next entry the cycle after a pop.
module nexi_uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_16x_bps,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]      mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     level_reg;
  logic [AW:0]     level_next;
  logic            wr_en;
  logic            rd_en;
  logic [DEPTH-1:0] wr_sel;

  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;
  assign dout  = mem_reg[rd_ptr_reg];

  // A push into a full FIFO is legal only when a pop frees a slot that cycle.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en & (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_16x_bps) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_sel[i]) mem_reg[i] <= din;
    end
  end

  always_comb begin
    level_next = level_reg;
    if (wr_en && !rd_en)      level_next = level_reg + 1'b1;
    else if (rd_en && !wr_en) level_next = level_reg - 1'b1;
  end

  always_ff @(posedge clk_16x_bps) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/nexi_uart_rx_ctrl.sv
// Receive-side controller: runs the data_ready/read_ack handshake, buffers
// bytes in a FIFO for a valid/ready host stream, and tracks overruns.
module nexi_uart_rx_ctrl
  import nexi_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk_16x_bps,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  output logic                 rx_ack,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AW:0]          level,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_cnt,
  input  logic                 overrun_clr
);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [1:0] guard_cnt_reg;
  logic [1:0] guard_cnt_next;
  logic       rx_ack_reg;
  logic       rx_ack_next;
  overrun_t   ovr_reg;
  overrun_t   ovr_next;

  logic capture;
  logic pop;
  logic push;
  logic drop;
  logic fifo_full;
  logic fifo_empty;

  assign capture = (state_reg == ST_IDLE) & enable & rx_ready;
  assign pop     = m_valid & m_ready;
  assign push    = capture & (~fifo_full | pop);
  assign drop    = capture & fifo_full & ~pop;

  nexi_uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_16x_bps (clk_16x_bps),
    .rst_n       (rst_n),
    .push        (push),
    .din         (rx_data),
    .pop         (pop),
    .dout        (m_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .level       (level)
  );

  assign m_valid = ~fifo_empty;

  always_comb begin
    state_next     = state_reg;
    guard_cnt_next = guard_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (capture) state_next = ST_ACK;
      end
      ST_ACK: begin
        if (!rx_ready) begin
          state_next     = ST_GUARD;
          guard_cnt_next = GUARD_CYCLES;
        end
      end
      ST_GUARD: begin
        guard_cnt_next = guard_cnt_reg - 2'd1;
        if (guard_cnt_next == 2'd0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rx_ack_next = (state_next == ST_ACK);
  assign rx_ack      = rx_ack_reg;

  // A clear wins over a same-cycle drop; that drop is not counted.
  always_comb begin
    ovr_next = ovr_reg;
    if (overrun_clr) begin
      ovr_next.flag = 1'b0;
      ovr_next.cnt  = '0;
    end else if (drop) begin
      ovr_next.flag = 1'b1;
      ovr_next.cnt  = sat_inc(ovr_reg.cnt);
    end
  end

  assign overrun     = ovr_reg.flag;
  assign overrun_cnt = ovr_reg.cnt;

  always_ff @(posedge clk_16x_bps) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      guard_cnt_reg <= '0;
      rx_ack_reg    <= 1'b0;
      ovr_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      guard_cnt_reg <= guard_cnt_next;
      rx_ack_reg    <= rx_ack_next;
      ovr_reg       <= ovr_next;
    end
  end

endmodule

// File: doc/nexi_uart_rx_ctrl.md
# nexi_uart_rx_ctrl

Receive-side controller for the minimal UART. It sequences the `nexi_uart_rx` read handshake (`data_ready` / `read_ack`), drains each received byte into a small synchronous FIFO, and presents the bytes to the host through a valid/ready stream. It also detects and counts overruns.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `AW`, default 2: log2(`DEPTH`).
- `clk_16x_bps`  in  1: receiver clock; the block is fully synchronous to it.
- `rst_n`  in  1: reset, synchronous, active-low.
- `enable`  in  1: when low, no new byte capture; a handshake already in progress completes.
- `rx_data`  in  8: byte from the receiver.
- `rx_ready`  in  1: receiver `data_ready`.
- `rx_ack`  out  1: to receiver `read_ack`; registered.
- `m_data`  out  8: FIFO head byte.
- `m_valid`  out  1: FIFO not empty.
- `m_ready`  in  1: host pop; a pop occurs when `m_valid & m_ready`.
- `level`  out  AW+1: FIFO occupancy, 0..`DEPTH`.
- `overrun`  out  1: sticky flag, set when a byte is dropped.
- `overrun_cnt`  out  8: dropped-byte count, saturates at 255.
- `overrun_clr`  in  1: clears `overrun` and `overrun_cnt`.

## Operation
- **FSM states:**
  - IDLE: `rx_ack` = 0. When `enable & rx_ready`, capture `rx_data` and go to ACK.
  - ACK: `rx_ack` = 1. Stay in ACK while `rx_ready` is high. When `rx_ready` is low, go to GUARD with `guard_cnt` = 2.
  - GUARD: `rx_ack` = 0. Decrement `guard_cnt`; at 0 go to IDLE. This lets the receiver's 2-flop ack synchronizer see the low level before the next capture.
- **Capture:** on the IDLE→ACK edge, push `rx_data` if the FIFO is not full or a pop happens in the same cycle. Otherwise drop the byte, set `overrun`, and increment `overrun_cnt` (saturating). The ack is still issued either way, so the receiver is freed.
- **FIFO:**
  - `DEPTH` entries with `AW`-bit read and write pointers that wrap modulo `DEPTH`.
  - `level` is updated +1 on push only, −1 on pop only, unchanged on both or neither.
  - `m_data` is memory[rd_ptr], read combinationally from registers.
- **Overrun clear vs. set:** `overrun_clr` has priority over a same-cycle overrun set. The drop in that cycle is lost from the count, and the flag ends up 0.
- **`enable` deasserted** in ACK or GUARD: the sequence finishes normally. IDLE then stays idle while `rx_ready` remains high.
- **Reset:** every state element takes the value listed under Timing at the next `clk_16x_bps` edge with `rst_n` low, including mid-handshake. The FIFO contents are discarded.

## Timing
- **Reset values:** `rx_ack` = 0, `m_valid` = 0, `m_data` = 0 (memory reset to 0), `level` = 0, `overrun` = 0, `overrun_cnt` = 0, FSM = IDLE.
- **Capture latency:** `rx_ready` is sampled high at edge N. At N, the byte is written and `rx_ack` goes to 1. `m_valid` is high after N if the FIFO was empty.
- **Handshake with the receiver:**
  - The receiver's synchronizer delay causes `rx_ready` to fall after edge N+3.
  - The FSM sees the low level at edge N+4 and drives `rx_ack` low.
  - GUARD covers edges N+5 and N+6; IDLE is re-entered at N+6.
  - If `rx_ready` does not fall, the FSM waits in ACK indefinitely. There is no timeout.
- **Pop:** `m_data` and `m_valid` reflect the next entry in the cycle after the pop edge.
- **Throughput:** one byte per 7 cycles maximum, well above the UART frame rate of 160 cycles per byte.

## Structure
- **Shared package `nexi_uart_pkg`:** FSM state encodings (IDLE, ACK, GUARD), `GUARD_CYCLES` = 2, overrun counter width 8.
- **Sub-module `nexi_uart_sync_fifo`:**
  - Parameters `DEPTH`/`AW`.
  - Ports: push/din, pop/dout, `full`, `empty`, `level`.
  - Synchronous reset.
- **Top level:** the FSM, capture logic and overrun logic.

## Test plan
- **Single byte:** 0xA5 with `rx_ready` high, modeled receiver clearing `rx_ready` 3 cycles after `rx_ack`, `m_ready` = 0. Expect:
  - `m_valid` = 1, `m_data` = 0xA5, `level` = 1.
  - `rx_ack` high for exactly 4 cycles.
  - Return to IDLE 2 cycles later.
- **Fill and overrun:** 5 bytes 0x01–0x05 with `DEPTH` = 4 and no pops. Expect:
  - `level` = 4, `overrun` = 1, `overrun_cnt` = 1.
  - Pops yield 0x01, 0x02, 0x03, 0x04 in order; 0x05 is absent.
- **Push and pop in the same cycle while full:** capture edge coincides with `m_ready` = 1. Expect no overrun, `level` remains 4, and the head advances.
- **Clear priority:** `overrun_clr` asserted on the same edge as a dropped byte. Expect `overrun` = 0 and `overrun_cnt` = 0.
- **`enable` low:** deassert `enable` during ACK. Expect the handshake to complete, then a later `rx_ready` to be ignored: no ack and `level` unchanged until `enable` = 1.
- **Reset mid-handshake:** `rst_n` low during ACK with `level` = 2. Expect next edge `rx_ack` = 0, `level` = 0, `m_valid` = 0, `m_data` = 0.
